// File: rtl/r2otfc_if.sv
// Digit-stream and result bundle for the radix-2 on-the-fly converter.
// The master drives digits; the slave (converter) returns the result and status.
interface r2otfc_if #(
    parameter int unsigned N = 16
);
    logic [1:0] d_in;
    logic       d_valid;
    logic       d_first;
    logic [N:0] q_out;
    logic       q_valid;
    logic       busy;
    logic       err;

    modport master (
        output d_in, d_valid, d_first,
        input  q_out, q_valid, busy, err
    );

    modport slave (
        input  d_in, d_valid, d_first,
        output q_out, q_valid, busy, err
    );
endinterface

// File: rtl/r2otfc.sv
// Radix-2 on-the-fly converter: MSDF signed digits to two's complement.
// It keeps Q and QM = Q - 1 ulp, so no carry ever has to propagate.
module r2otfc #(
    parameter int unsigned N = 16
) (
    input logic     clk,
    input logic     reset,
    r2otfc_if.slave bus
);
    localparam int unsigned W  = N + 1;
    localparam int unsigned CW = $clog2(N + 1);

    typedef enum logic {S_IDLE, S_CONV} state_t;

    if (N < 2) begin : g_n_check
        $error("r2otfc: N must be at least 2");
    end

    state_t          r_state;
    logic [CW-1:0]   r_cnt;
    logic [W-1:0]    r_q;
    logic [W-1:0]    r_qm;
    logic [W-1:0]    r_q_out;
    logic            r_q_valid;
    logic            r_busy;
    logic            r_err;

    logic            w_illegal;
    logic [W-1:0]    w_q_base;
    logic [W-1:0]    w_qm_base;
    logic [W-1:0]    w_q_nxt;
    logic [W-1:0]    w_qm_nxt;

    // A first digit always starts from Q = 0, QM = -1, regardless of state.
    always_comb begin
        w_illegal = (bus.d_in == 2'b10);
        w_q_base  = bus.d_first ? '0 : r_q;
        w_qm_base = bus.d_first ? '1 : r_qm;
        w_q_nxt   = '0;
        w_qm_nxt  = '0;
        case (bus.d_in)
            2'b01: begin
                w_q_nxt  = (w_q_base << 1) | W'(1);
                w_qm_nxt = w_q_base << 1;
            end
            2'b11: begin
                w_q_nxt  = (w_qm_base << 1) | W'(1);
                w_qm_nxt = w_qm_base << 1;
            end
            default: begin
                w_q_nxt  = w_q_base << 1;
                w_qm_nxt = (w_qm_base << 1) | W'(1);
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state   <= S_IDLE;
            r_cnt     <= '0;
            r_q       <= '0;
            r_qm      <= '1;
            r_q_out   <= '0;
            r_q_valid <= 1'b0;
            r_busy    <= 1'b0;
            r_err     <= 1'b0;
        end else begin
            r_q_valid <= 1'b0;
            r_err     <= 1'b0;
            if (bus.d_valid) begin
                if (w_illegal) begin
                    r_err <= 1'b1;
                end
                if (bus.d_first) begin
                    if (r_state == S_CONV) begin
                        r_err <= 1'b1;
                    end
                    r_q     <= w_q_nxt;
                    r_qm    <= w_qm_nxt;
                    r_cnt   <= CW'(1);
                    r_busy  <= 1'b1;
                    r_state <= S_CONV;
                end else if (r_state == S_IDLE) begin
                    r_err <= 1'b1;
                end else begin
                    r_q  <= w_q_nxt;
                    r_qm <= w_qm_nxt;
                    if (r_cnt == CW'(N - 1)) begin
                        r_q_out   <= w_q_nxt;
                        r_q_valid <= 1'b1;
                        r_cnt     <= '0;
                        r_busy    <= 1'b0;
                        r_state   <= S_IDLE;
                    end else begin
                        r_cnt <= r_cnt + CW'(1);
                    end
                end
            end
        end
    end

    assign bus.q_out   = r_q_out;
    assign bus.q_valid = r_q_valid;
    assign bus.busy    = r_busy;
    assign bus.err     = r_err;
endmodule
